conv_encoder_framed: RTL

Rate-1/2, constraint-length-3 convolutional encoder, the transmit-side counterpart of the Viterbi decoder. It accepts one data bit per handshake and emits one 2-bit coded symbol per accepted bit. After each frame it appends K-1 zero tail bits, so the decoder always starts and ends a frame in state 00. It sits between the bit source and the channel / error-injection stage.

---
 rtl/conv_enc_pkg.sv | 20 ++
 rtl/conv_enc_core.sv | 39 +++
 rtl/conv_encoder_framed.sv | 120 ++++++++++++
 3 files changed

// File: rtl/conv_enc_pkg.sv
// Shared types and helpers for the framed rate-1/2, K=3 convolutional encoder.
package conv_enc_pkg;

    localparam int unsigned K = 3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } state_t;

    typedef logic [1:0] sym_t;

    // One generator tap set applied to {current bit, s1, s0}.
    function automatic logic parity(input logic [K-1:0] gen, input logic u, input logic s1,
                                    input logic s0);
        return ^(gen & {u, s1, s0});
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Shift register and generator logic; emits one registered symbol per shift.
module conv_enc_core
    import conv_enc_pkg::*;
#(
    parameter logic [K-1:0] G0 = 3'b111,
    parameter logic [K-1:0] G1 = 3'b101
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic u,
    input  logic clr,
    output sym_t sym
);

    logic s1;
    logic s0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1  <= 1'b0;
            s0  <= 1'b0;
            sym <= 2'b00;
        end else begin
            if (shift_en) begin
                sym <= {parity(G0, u, s1, s0), parity(G1, u, s1, s0)};
            end
            // clr wins over the shift so the last tail symbol leaves the register at 00
            if (clr) begin
                s1 <= 1'b0;
                s0 <= 1'b0;
            end else if (shift_en) begin
                s1 <= u;
                s0 <= s1;
            end
        end
    end

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed convolutional encoder: handshake, frame/tail FSM and frame counter around the core.
module conv_encoder_framed
    import conv_enc_pkg::*;
#(
    parameter int unsigned  FRAME_LEN = 256,
    parameter logic [K-1:0] G0        = 3'b111,
    parameter logic [K-1:0] G1        = 3'b101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        d_in,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [1:0]  d_out,
    output logic        sof_o,
    output logic        eof_o,
    output logic [15:0] frame_ct_o
);

    localparam logic [16:0] FrameLen = 17'(FRAME_LEN);

    state_t      state;
    logic [15:0] bit_cnt;
    logic        tail_cnt;

    logic accept;
    logic last_bit;
    logic in_tail;
    logic shift_en;
    logic core_u;
    logic core_clr;
    sym_t core_sym;

    assign accept   = enable_i && ready_o;
    assign last_bit = ({1'b0, bit_cnt} + 17'd1) == FrameLen;
    assign in_tail  = (state == TAIL);
    assign shift_en = accept || in_tail;
    assign core_u   = in_tail ? 1'b0 : d_in;
    assign core_clr = in_tail && tail_cnt;

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .u        (core_u),
        .clr      (core_clr),
        .sym      (core_sym)
    );

    assign d_out = core_sym;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= 16'd0;
            tail_cnt   <= 1'b0;
            frame_ct_o <= 16'd0;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            sof_o      <= 1'b0;
            eof_o      <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    // flush without an accepted bit has no frame to end
                    if (accept) begin
                        valid_o <= 1'b1;
                        sof_o   <= 1'b1;
                        bit_cnt <= 16'd1;
                        if (last_bit || flush_i) begin
                            state   <= TAIL;
                            ready_o <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        valid_o <= 1'b1;
                        bit_cnt <= bit_cnt + 16'd1;
                        if (last_bit || flush_i) begin
                            state   <= TAIL;
                            ready_o <= 1'b0;
                        end
                    end else if (flush_i) begin
                        state   <= TAIL;
                        ready_o <= 1'b0;
                    end
                end
                TAIL: begin
                    valid_o <= 1'b1;
                    if (tail_cnt) begin
                        eof_o      <= 1'b1;
                        frame_ct_o <= frame_ct_o + 16'd1;
                        bit_cnt    <= 16'd0;
                        tail_cnt   <= 1'b0;
                        ready_o    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        tail_cnt <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
